fpaddsub_result_stage: RTL and testbench

- Registered output stage directly downstream of the FP add/sub exception stage.
- Accepts the final result word and its 5-bit exception flags over a valid/ready handshake, and buffers them in a 2-entry skid FIFO.
- Canonicalises invalid results to a quiet NaN and keeps an IEEE-style sticky status register, a masked interrupt and a saturating result counter.
- Provides the clean registered boundary between the combinational add/sub pipeline and the consuming datapath.

---
 rtl/fpaddsub_result_stage.sv | 101 ++++++++++
 tb/tb_fpaddsub_result_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpaddsub_result_stage.sv
// Registered result stage after the FP add/sub exception stage: 2-entry skid FIFO,
// invalid-to-quiet-NaN canonicalisation, sticky status, masked irq and saturating count.
module fpaddsub_result_stage #(
    parameter int DWIDTH   = 16,
    parameter int EXPONENT = 5,
    parameter int MANTISSA = 10,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_result,
    input  logic [4:0]        in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_result,
    output logic [4:0]        out_flags,
    input  logic [4:0]        flag_mask,
    input  logic              flags_clr,
    output logic [4:0]        sticky_flags,
    output logic              irq,
    output logic [CNT_W-1:0]  result_cnt
);

    localparam int FLAG_INVALID = 1;
    localparam logic [DWIDTH-1:0] QNAN = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
    localparam logic [1:0] FULL = 2'd2;

    logic [DWIDTH-1:0] data_q  [2];
    logic [4:0]        flags_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] store_result;
    logic [4:0]        sticky_next;
    logic [CNT_W-1:0]  cnt_next;

    // Ready depends only on registered occupancy, so no combinational path from out_ready.
    always_comb begin
        in_ready     = ~rst & (count != FULL);
        out_valid    = ~rst & (count != 2'd0);
        push         = in_valid & in_ready;
        pop          = out_valid & out_ready;
        store_result = in_flags[FLAG_INVALID] ? QNAN : in_result;
        out_result   = '0;
        out_flags    = '0;
        if (out_valid) begin
            out_result = data_q[rd_ptr];
            out_flags  = flags_q[rd_ptr];
        end
    end

    always_comb begin
        sticky_next = sticky_flags;
        cnt_next    = result_cnt;
        if (flags_clr) begin
            // A push coinciding with the clear is counted and its flags retained.
            sticky_next = push ? in_flags : 5'd0;
            cnt_next    = push ? CNT_W'(1) : '0;
        end else if (push) begin
            sticky_next = sticky_flags | in_flags;
            if (result_cnt != {CNT_W{1'b1}}) begin
                cnt_next = result_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            sticky_flags <= 5'd0;
            irq          <= 1'b0;
            result_cnt   <= '0;
        end else begin
            count        <= count + {1'b0, push} - {1'b0, pop};
            wr_ptr       <= wr_ptr ^ push;
            rd_ptr       <= rd_ptr ^ pop;
            sticky_flags <= sticky_next;
            irq          <= |(sticky_next & flag_mask);
            result_cnt   <= cnt_next;
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy gates every read,
    // so stale contents are never visible and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr]  <= store_result;
            flags_q[wr_ptr] <= in_flags;
        end
    end

endmodule

// File: tb/tb_fpaddsub_result_stage.sv
// Self-checking bench for fpaddsub_result_stage: per-cycle queue scoreboard plus
// a vector table and directed sequences for stall, sticky, saturation and reset.
module tb_fpaddsub_result_stage;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [4:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  flag_mask;
    logic        flags_clr;
    logic [4:0]  sticky_flags;
    logic        irq;
    logic [CNT_W-1:0] result_cnt;

    fpaddsub_result_stage #(
        .DWIDTH(16), .EXPONENT(5), .MANTISSA(10), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .flag_mask(flag_mask), .flags_clr(flags_clr),
        .sticky_flags(sticky_flags), .irq(irq), .result_cnt(result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
    } entry_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
        logic [15:0] exp_res;
    } vec_t;

    entry_t sb[$];
    logic [4:0] sticky_m;
    logic       irq_m;
    int         cnt_m;
    logic       ordy_g;
    logic [4:0] mask_g;
    int         total;
    int         bad;
    vec_t       vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] canon(input logic [15:0] res, input logic [4:0] flg);
        return flg[1] ? 16'h7E00 : res;
    endfunction

    // One clock cycle: drive, compare against model at negedge, advance model at posedge.
    task automatic cycle(input logic v, input logic [15:0] res, input logic [4:0] flg,
                         input logic [15:0] exp_res, input logic clr, input logic r,
                         output logic accepted);
        logic exp_ov, exp_ir, push, pop;
        logic [4:0] st_n;
        entry_t e;
        rst = r; in_valid = v; in_result = res; in_flags = flg;
        out_ready = ordy_g; flags_clr = clr; flag_mask = mask_g;
        @(negedge clk);
        exp_ov = !r && (sb.size() != 0);
        exp_ir = !r && (sb.size() < 2);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            check("out_result", {16'd0, out_result}, {16'd0, sb[0].res});
            check("out_flags", {27'd0, out_flags}, {27'd0, sb[0].flg});
        end else begin
            check("out_result_idle", {16'd0, out_result}, 32'd0);
            check("out_flags_idle", {27'd0, out_flags}, 32'd0);
        end
        check("sticky", {27'd0, sticky_flags}, {27'd0, sticky_m});
        check("irq", {31'd0, irq}, {31'd0, irq_m});
        check("result_cnt", {28'd0, result_cnt}, cnt_m);
        push = v && exp_ir;
        pop  = exp_ov && ordy_g;
        @(posedge clk);
        if (r) begin
            sb.delete();
            sticky_m = '0; irq_m = 1'b0; cnt_m = 0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                e.res = exp_res; e.flg = flg;
                sb.push_back(e);
            end
            if (clr) begin
                st_n  = push ? flg : 5'd0;
                cnt_m = push ? 1 : 0;
            end else begin
                st_n = push ? (sticky_m | flg) : sticky_m;
                if (push && cnt_m < CNT_MAX) cnt_m++;
            end
            sticky_m = st_n;
            irq_m    = |(st_n & mask_g);
        end
        accepted = push;
        #1;
    endtask

    task automatic send(input logic [15:0] res, input logic [4:0] flg,
                        input logic [15:0] exp_res, input logic clr);
        logic acc;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, res, flg, exp_res, clr, 1'b0, acc);
            if (acc) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic clr);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 5'd0, 16'h0, clr, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        total = 0; bad = 0;
        vecs[0] = '{16'h3C00, 5'b00000, 16'h3C00};
        vecs[1] = '{16'h7C01, 5'b00010, 16'h7E00};
        vecs[2] = '{16'hFC00, 5'b10000, 16'hFC00};
        vecs[3] = '{16'h1234, 5'b00011, 16'h7E00};
        vecs[4] = '{16'hFFFF, 5'b11101, 16'hFFFF};
        vecs[5] = '{16'h0001, 5'b01000, 16'h0001};
        vecs[6] = '{16'h7E00, 5'b11111, 16'h7E00};
        vecs[7] = '{16'h8000, 5'b00100, 16'h8000};

        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0;
        out_ready = 1'b0; flags_clr = 1'b0; flag_mask = '0;
        ordy_g = 1'b1; mask_g = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        sticky_m = '0; irq_m = 1'b0; cnt_m = 0;

        // Reset state held, then single pass-through transaction.
        cycle(1'b0, 16'h0, 5'd0, 16'h0, 1'b0, 1'b1, acc);
        send(16'h3C00, 5'd0, canon(16'h3C00, 5'd0), 1'b0);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_result", {16'd0, out_result}, 32'h3C00);
        idle(2, 1'b0);
        check("single_cnt", {28'd0, result_cnt}, 32'd1);

        // Back-pressure: third push held until downstream drains.
        ordy_g = 1'b0;
        send(16'h4000, 5'd0, 16'h4000, 1'b0);
        send(16'h4200, 5'd0, 16'h4200, 1'b0);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 16'h4400, 5'd0, 16'h4400, 1'b0, 1'b0, acc);
        check("held_third", {31'd0, acc}, 32'd0);
        cycle(1'b1, 16'h4400, 5'd0, 16'h4400, 1'b0, 1'b0, acc);
        ordy_g = 1'b1;
        send(16'h4400, 5'd0, 16'h4400, 1'b0);
        idle(3, 1'b0);

        // Invalid -> quiet NaN with masked interrupt.
        mask_g = 5'b00010;
        send(16'h7C01, 5'b00010, canon(16'h7C01, 5'b00010), 1'b0);
        check("nan_result", {16'd0, out_result}, 32'h7E00);
        check("nan_sticky", {27'd0, sticky_flags}, 32'b00010);
        check("nan_irq", {31'd0, irq}, 32'd1);
        idle(1, 1'b0);

        // Mask change takes a cycle to reach irq.
        mask_g = 5'd0;
        idle(2, 1'b0);
        mask_g = 5'b00010;
        idle(2, 1'b0);

        // Sticky accumulation and clear-with-push.
        idle(1, 1'b1);
        send(16'h3800, 5'b10001, 16'h3800, 1'b0);
        send(16'h3A00, 5'b01000, 16'h3A00, 1'b0);
        check("sticky_or", {27'd0, sticky_flags}, 32'b11001);
        send(16'h3E00, 5'b00001, 16'h3E00, 1'b1);
        check("clr_push_sticky", {27'd0, sticky_flags}, 32'b00001);
        check("clr_push_cnt", {28'd0, result_cnt}, 32'd1);
        idle(2, 1'b0);

        // Vector table streamed at full rate.
        for (int i = 0; i < 8; i++) send(vecs[i].res, vecs[i].flg, vecs[i].exp_res, 1'b0);
        idle(3, 1'b0);

        // Counter saturation.
        idle(1, 1'b1);
        for (int i = 0; i < 17; i++) send(16'(i), 5'd0, 16'(i), 1'b0);
        idle(2, 1'b0);
        check("cnt_saturated", {28'd0, result_cnt}, 32'd15);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r16;
            logic [4:0]  f5;
            r16 = 16'($urandom);
            f5  = 5'($urandom);
            ordy_g = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) mask_g = 5'($urandom);
            cycle(1'($urandom), r16, f5, canon(r16, f5), ($urandom_range(0, 19) == 0), 1'b0, acc);
        end
        ordy_g = 1'b1;
        idle(3, 1'b0);

        // Reset while full discards entries; first push afterwards is normal.
        ordy_g = 1'b0;
        send(16'hAAAA, 5'b00100, 16'hAAAA, 1'b0);
        send(16'hBBBB, 5'b00001, 16'hBBBB, 1'b0);
        cycle(1'b1, 16'hCCCC, 5'd0, 16'hCCCC, 1'b0, 1'b1, acc);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_cnt", {28'd0, result_cnt}, 32'd0);
        ordy_g = 1'b1;
        idle(1, 1'b0);
        send(16'h5555, 5'd0, 16'h5555, 1'b0);
        check("post_rst_result", {16'd0, out_result}, 32'h5555);
        idle(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
